// File: rtl/assoc_cache_pkg.sv
// Shared types and entry-layout helpers for the set-associative cache.
// The line store packs one entry as {tag, data}; valid, dirty and age are held separately.
package assoc_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic int f_tag_w(input int addr_w, input int set_bits);
    return addr_w - set_bits;
  endfunction

  function automatic int f_age_w(input int ways);
    return $clog2(ways);
  endfunction

  function automatic int f_data_off();
    return 0;
  endfunction

  function automatic int f_tag_off(input int data_w);
    return data_w;
  endfunction

  function automatic int f_line_w(input int tag_w, input int data_w);
    return tag_w + data_w;
  endfunction

endpackage

// File: rtl/assoc_cache_lru_set_update.sv
// Age-based LRU for one set: returns the refreshed age vector for an access
// to i_way and the way currently holding the oldest age.
module lru_set_update
  import assoc_cache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int AW   = f_age_w(WAYS)
) (
  input  logic [WAYS*AW-1:0] i_ages,
  input  logic [AW-1:0]      i_way,
  output logic [WAYS*AW-1:0] o_ages,
  output logic [AW-1:0]      o_oldest
);

  logic [AW-1:0] w_acc_age;

  // Accessed way becomes youngest; only ways younger than it age by one.
  always_comb begin
    o_ages    = '0;
    o_oldest  = '0;
    w_acc_age = i_ages[int'(i_way)*AW +: AW];
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == i_way) begin
        o_ages[w*AW +: AW] = '0;
      end else if (i_ages[w*AW +: AW] < w_acc_age) begin
        o_ages[w*AW +: AW] = i_ages[w*AW +: AW] + AW'(1);
      end else begin
        o_ages[w*AW +: AW] = i_ages[w*AW +: AW];
      end
      o_oldest = (i_ages[w*AW +: AW] == AW'(WAYS - 1)) ? AW'(w) : o_oldest;
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// Write-back, write-allocate set-associative cache, one word per line, with
// age-based LRU replacement and saturating hit/miss/writeback statistics.
module assoc_cache
  import assoc_cache_pkg::*;
#(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 10,
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       wb_cnt
);

  localparam int TAG_W    = f_tag_w(ADDR_W, SET_BITS);
  localparam int AW       = f_age_w(WAYS);
  localparam int SETS     = 2 ** SET_BITS;
  localparam int LINE_W   = f_line_w(TAG_W, DATA_W);
  localparam int TAG_OFF  = f_tag_off(DATA_W);
  localparam int DATA_OFF = f_data_off();

  state_t              r_state, w_state_nxt;
  logic [WAYS-1:0]     r_valid [SETS];
  logic [WAYS-1:0]     r_dirty [SETS];
  logic [WAYS*AW-1:0]  r_age   [SETS];
  logic [LINE_W-1:0]   r_line  [SETS][WAYS];
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic [AW-1:0]       r_victim;

  logic [SET_BITS-1:0] w_idx, w_cap_idx, w_lru_set;
  logic [TAG_W-1:0]    w_tag, w_cap_tag;
  logic [WAYS-1:0]     w_hit_vec;
  logic                w_hit, w_accept, w_ack, w_fill_done, w_lru_upd, w_victim_dirty;
  logic [AW-1:0]       w_hit_way, w_victim, w_lru_way, w_lru_oldest;
  logic [WAYS*AW-1:0]  w_lru_ages, w_lru_new;
  logic [LINE_W-1:0]   w_victim_line;

  assign w_idx       = req_addr[SET_BITS-1:0];
  assign w_tag       = req_addr[ADDR_W-1:SET_BITS];
  assign w_cap_idx   = r_addr[SET_BITS-1:0];
  assign w_cap_tag   = r_addr[ADDR_W-1:SET_BITS];
  assign req_ready   = (r_state == ST_IDLE);
  assign w_accept    = req_valid && (r_state == ST_IDLE);
  // Acks are only meaningful against an outstanding request.
  assign w_ack       = mem_ack && mem_req;
  assign w_fill_done = (r_state == ST_FILL) && w_ack;
  assign w_hit       = |w_hit_vec;

  // Tag compare; lowest matching way wins.
  always_comb begin
    w_hit_vec = '0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_valid[w_idx][w] && (r_line[w_idx][w][TAG_OFF +: TAG_W] == w_tag);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_hit_way = w_hit_vec[w] ? AW'(w) : w_hit_way;
    end
  end

  // Victim: lowest invalid way, otherwise the oldest.
  always_comb begin
    w_victim = w_lru_oldest;
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_victim = r_valid[w_idx][w] ? w_victim : AW'(w);
    end
  end

  assign w_victim_line  = r_line[w_idx][w_victim];
  assign w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];

  assign w_lru_set  = (r_state == ST_IDLE) ? w_idx : w_cap_idx;
  assign w_lru_way  = (r_state == ST_IDLE) ? w_hit_way : r_victim;
  assign w_lru_ages = r_age[w_lru_set];
  assign w_lru_upd  = (w_accept && w_hit) || w_fill_done;

  lru_set_update #(.WAYS(WAYS), .AW(AW)) u_lru (
    .i_ages  (w_lru_ages),
    .i_way   (w_lru_way),
    .o_ages  (w_lru_new),
    .o_oldest(w_lru_oldest)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_accept)          w_state_nxt = ST_IDLE;
        else if (w_hit)         w_state_nxt = ST_RESP;
        else if (w_victim_dirty) w_state_nxt = ST_WB;
        else                    w_state_nxt = ST_FILL;
      end
      ST_WB:   w_state_nxt = w_ack ? ST_FILL : ST_WB;
      ST_FILL: w_state_nxt = w_ack ? ST_RESP : ST_FILL;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_victim   <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_cnt    <= 32'd0;
      miss_cnt   <= 32'd0;
      wb_cnt     <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_we     <= req_we;
            r_victim <= w_victim;
            if (w_hit) begin
              resp_valid <= 1'b1;
              resp_hit   <= 1'b1;
              resp_rdata <= req_we ? '0 : r_line[w_idx][w_hit_way][DATA_OFF +: DATA_W];
              if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
            end else if (w_victim_dirty) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {w_victim_line[TAG_OFF +: TAG_W], w_idx};
              mem_wdata <= w_victim_line[DATA_OFF +: DATA_W];
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= req_addr;
              mem_wdata <= '0;
            end
          end
        end
        ST_WB: begin
          if (w_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (wb_cnt != 32'hFFFF_FFFF) wb_cnt <= wb_cnt + 32'd1;
          end
        end
        // Entered straight from IDLE with mem_req up, or after a writeback with it down for a cycle.
        ST_FILL: begin
          if (w_ack) begin
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_rdata <= r_we ? '0 : mem_rdata;
            if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= r_addr;
            mem_wdata <= '0;
          end
        end
        default: begin
          r_victim <= r_victim;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_age[s][w*AW +: AW] <= AW'(w);
        end
      end
    end else begin
      if (w_lru_upd) r_age[w_lru_set] <= w_lru_new;
      if (w_accept && w_hit && req_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
      if (w_fill_done) begin
        r_valid[w_cap_idx][r_victim] <= 1'b1;
        r_dirty[w_cap_idx][r_victim] <= r_we;
      end
    end
  end

  // Tag/data store carries no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_accept && w_hit && req_we) begin
      r_line[w_idx][w_hit_way] <= {w_tag, req_wdata};
    end else if (w_fill_done) begin
      r_line[w_cap_idx][r_victim] <= {w_cap_tag, (r_we ? r_wdata : mem_rdata)};
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache (4 ways, 4 sets, 8-bit word address) with a
// small external memory responder driven from the access task.
module tb_assoc_cache;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [256];

  logic [31:0] a_hit, a_rdata, a_lat, a_wb_addr, a_wb_data, a_fill_addr;
  int          a_nwb, a_nfill, a_got, a_bad_stable, a_bad_ready, a_bad_drop, a_bad_double;

  assoc_cache #(.WAYS(4), .SET_BITS(2), .ADDR_W(8), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_hit  (resp_hit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .wb_cnt    (wb_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One request; the memory side acks each mem_req after 'delay' waiting cycles.
  task automatic access(input logic we, input logic [7:0] addr, input logic [31:0] wd, input int delay);
    int          waitc;
    logic        prev_ack;
    logic        s_we;
    logic [7:0]  s_addr;
    logic [31:0] s_wd;
    a_hit = 32'd0; a_rdata = 32'd0; a_lat = 32'd0; a_wb_addr = 32'd0; a_wb_data = 32'd0;
    a_fill_addr = 32'd0; a_nwb = 0; a_nfill = 0; a_got = 0;
    a_bad_stable = 0; a_bad_ready = 0; a_bad_drop = 0; a_bad_double = 0;
    waitc = 0; prev_ack = 1'b0; s_we = 1'b0; s_addr = 8'd0; s_wd = 32'd0;
    @(negedge clk);
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'd0; req_wdata = 32'd0;
    for (int c = 0; c < 400; c++) begin
      mem_ack = 1'b0;
      if (prev_ack && mem_req) a_bad_drop = 1;
      prev_ack = 1'b0;
      if (resp_valid) begin
        a_got = 1; a_hit = {31'd0, resp_hit}; a_rdata = resp_rdata; a_lat = c + 1;
        break;
      end
      if (mem_req) begin
        if (req_ready) a_bad_ready = 1;
        if (waitc == 0) begin
          s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
        end else if (mem_we !== s_we || mem_addr !== s_addr || mem_wdata !== s_wd) begin
          a_bad_stable = 1;
        end
        if (waitc >= delay) begin
          if (mem_we) begin
            a_nwb++; a_wb_addr = {24'd0, mem_addr}; a_wb_data = mem_wdata;
            mem_model[mem_addr] = mem_wdata;
          end else begin
            a_nfill++; a_fill_addr = {24'd0, mem_addr};
            mem_rdata = mem_model[mem_addr];
          end
          mem_ack = 1'b1; prev_ack = 1'b1; waitc = 0;
        end else begin
          waitc++;
        end
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk("resp_seen", a_got, 32'd1);
    chk("mem_req_drop_after_ack", a_bad_drop, 32'd0);
    if (a_got != 0) begin
      @(negedge clk);
      if (resp_valid) a_bad_double = 1;
    end
    chk("single_resp_pulse", a_bad_double, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'd0; req_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    for (int i = 0; i < 256; i++) mem_model[i] = 32'hA000_0000 + i;
    mem_model[8'h10] = 32'hCAFE_0001;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_counters", hit_cnt | miss_cnt | wb_cnt, 32'd0);
    rst_n = 1'b1;

    // Cold read miss, then the same address hits one cycle after acceptance
    access(1'b0, 8'h10, 32'd0, 2);
    chk("t1_miss_hit", a_hit, 32'd0);
    chk("t1_miss_rdata", a_rdata, 32'hCAFE_0001);
    chk("t1_nfill", a_nfill, 32'd1);
    chk("t1_nwb", a_nwb, 32'd0);
    chk("t1_fill_addr", a_fill_addr, 32'h10);
    access(1'b0, 8'h10, 32'd0, 2);
    chk("t1_rehit", a_hit, 32'd1);
    chk("t1_rehit_rdata", a_rdata, 32'hCAFE_0001);
    chk("t1_hit_latency", a_lat, 32'd1);
    chk("t1_hit_no_mem", a_nfill + a_nwb, 32'd0);
    chk("t1_miss_cnt", miss_cnt, 32'd1);
    chk("t1_hit_cnt", hit_cnt, 32'd1);

    // Write-allocate miss, then read hit with no memory traffic
    access(1'b1, 8'h14, 32'h1111_1111, 1);
    chk("t2_wr_hit", a_hit, 32'd0);
    chk("t2_wr_rdata", a_rdata, 32'd0);
    chk("t2_wr_fill_addr", a_fill_addr, 32'h14);
    chk("t2_wr_nwb", a_nwb, 32'd0);
    access(1'b0, 8'h14, 32'd0, 1);
    chk("t2_rd_hit", a_hit, 32'd1);
    chk("t2_rd_rdata", a_rdata, 32'h1111_1111);
    chk("t2_rd_no_mem", a_nfill + a_nwb, 32'd0);

    // LRU: fill set 0, touch 0x00, then 0x10 evicts the way holding 0x04
    do_reset();
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 8'(i * 4), 32'd0, 0);
      chk("t3_cold_miss", a_hit, 32'd0);
    end
    access(1'b0, 8'h00, 32'd0, 0);
    chk("t3_touch_hit", a_hit, 32'd1);
    chk("t3_touch_rdata", a_rdata, 32'hA000_0000);
    access(1'b0, 8'h10, 32'd0, 0);
    chk("t3_evict_hit", a_hit, 32'd0);
    chk("t3_evict_nwb", a_nwb, 32'd0);
    chk("t3_evict_rdata", a_rdata, 32'hCAFE_0001);
    access(1'b0, 8'h04, 32'd0, 0);
    chk("t3_04_evicted", a_hit, 32'd0);
    chk("t3_04_rdata", a_rdata, 32'hA000_0004);
    access(1'b0, 8'h00, 32'd0, 0);
    chk("t3_00_kept", a_hit, 32'd1);
    access(1'b0, 8'h0C, 32'd0, 0);
    chk("t3_0c_kept", a_hit, 32'd1);

    // Dirty eviction: writeback of 0x00 precedes the fill of 0x10
    do_reset();
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 8'(i * 4), 32'hD0D0_0000 + i * 4, 0);
      chk("t4_wr_miss", a_hit, 32'd0);
    end
    access(1'b0, 8'h10, 32'd0, 1);
    chk("t4_nwb", a_nwb, 32'd1);
    chk("t4_wb_addr", a_wb_addr, 32'h00);
    chk("t4_wb_data", a_wb_data, 32'hD0D0_0000);
    chk("t4_nfill", a_nfill, 32'd1);
    chk("t4_fill_addr", a_fill_addr, 32'h10);
    chk("t4_rdata", a_rdata, 32'hCAFE_0001);
    chk("t4_wb_cnt", wb_cnt, 32'd1);
    chk("t4_miss_cnt", miss_cnt, 32'd5);
    chk("t4_hit_cnt", hit_cnt, 32'd0);

    // Slow memory: 20 cycles per ack, outputs held stable and ready low
    access(1'b0, 8'h14, 32'd0, 20);
    chk("t5_wb_addr", a_wb_addr, 32'h04);
    chk("t5_wb_data", a_wb_data, 32'hD0D0_0004);
    chk("t5_fill_addr", a_fill_addr, 32'h14);
    chk("t5_rdata", a_rdata, 32'hA000_0014);
    chk("t5_stable", a_bad_stable, 32'd0);
    chk("t5_ready_low", a_bad_ready, 32'd0);
    chk("t5_wb_cnt", wb_cnt, 32'd2);

    // Reset in the middle of a writeback
    do_reset();
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 8'(i * 4), 32'hEEEE_0000 + i * 4, 0);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 8'd0;
    chk("t6_in_wb", {30'd0, mem_req, mem_we}, 32'd3);
    chk("t6_wb_addr", {24'd0, mem_addr}, 32'h00);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_mem", {30'd0, mem_req, mem_we}, 32'd0);
    chk("t6_rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("t6_rst_mem_wdata", mem_wdata, 32'd0);
    chk("t6_rst_resp", {30'd0, resp_valid, resp_hit}, 32'd0);
    chk("t6_rst_rdata", resp_rdata, 32'd0);
    chk("t6_rst_miss_cnt", miss_cnt, 32'd0);
    chk("t6_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("t6_stray_ack_resp", {31'd0, resp_valid}, 32'd0);
    chk("t6_stray_ack_wb_cnt", wb_cnt, 32'd0);
    access(1'b0, 8'h00, 32'd0, 0);
    chk("t6_post_rst_miss", a_hit, 32'd0);
    chk("t6_post_rst_nwb", a_nwb, 32'd0);
    chk("t6_post_rst_rdata", a_rdata, 32'hD0D0_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
